avalon_gpio_ctrl: RTL and testbench
===================================

# avalon_gpio_ctrl

Parametrised Avalon-MM GPIO peripheral that replaces the fixed 32-bit LED/switch PIO pair in the SoC fabric. Provides WIDTH output bits with atomic set/clear, WIDTH input bits with synchronisation and tick-based debouncing, per-bit rising/falling edge capture, and a maskable level interrupt to the CPU. Sits on the CPU-side Avalon bus; gpio_in/gpio_out connect to board switches, keys and LEDs.

## Interface
- WIDTH, 32: number of input and output bits, 1..32.
- DEBOUNCE_CYCLES, 50000: clk cycles per debounce sample tick, ≥1; 1 means sample every cycle.
- OUT_RESET, 0: gpio_out value on reset, WIDTH bits.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe, one cycle.
- avs_write  in  1  write strobe, one cycle.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- gpio_in  in  WIDTH  asynchronous external inputs.
- gpio_out  out  WIDTH  registered outputs.
- irq  out  1  level interrupt, registered.

## Operation
- Register map (word address): 0 DATA_IN (RO, debounced inputs); 1 DATA_OUT (RW); 2 OUT_SET (WO, write-1-set DATA_OUT); 3 OUT_CLR (WO, write-1-clear DATA_OUT); 4 IRQ_MASK (RW); 5 EDGE_CAP (R, W1C); 6 RISE_EN (RW); 7 FALL_EN (RW).
- Bits [31:WIDTH] ignored on write, read as 0. WO registers read 0.
- Input path: 2-flop synchroniser per bit (sync). Tick counter counts 0..DEBOUNCE_CYCLES-1, tick asserted on terminal count, then wraps to 0.
- On tick, per bit: s1←sync, s2←s1; if sync==s1==s2 (pre-update values) then deb←sync. Pulses shorter than 3 ticks never reach deb.
- Edge capture: at the edge where deb bit changes 0→1 with RISE_EN set, or 1→0 with FALL_EN set, EDGE_CAP bit ←1. Write-1-clear on address 5; same-cycle capture and clear on one bit → capture wins (bit stays 1).
- irq ← |(EDGE_CAP & IRQ_MASK) every cycle.
- gpio_out is DATA_OUT directly.

## Timing
- Reset (async, immediate): DATA_OUT=OUT_RESET, all other registers, synchronisers, s1/s2, deb, tick counter = 0; avs_readdata=0; irq=0.
- Reads: avs_readdata valid the cycle after avs_read; held until next read. No waitrequest; read and write never asserted together.
- Writes: take effect at the clk edge sampling avs_write; gpio_out changes same edge.
- DEBOUNCE_CYCLES=1, input changes before edge k: sync valid after k+1, deb and EDGE_CAP after k+4, irq after k+5. General case: deb latency 2 cycles + 3 ticks (worst case 2+3·DEBOUNCE_CYCLES).
- IRQ_MASK or EDGE_CAP clear: irq follows one cycle later.
- Reset asserted mid-debounce discards partial samples; deb restarts from 0 after deassertion, and a high input then produces a rising capture once stable 3 ticks.

## Test plan
- Reset: assert rst with OUT_RESET=0x5 → gpio_out=0x5, irq=0, read addr 0/5 → 0.
- Set/clear: write DATA_OUT=0xF0, OUT_SET=0x01, OUT_CLR=0x10 → gpio_out 0xF0, 0xF1, 0xE1 on successive edges; read addr 1 → 0xE1.
- Debounce (DEBOUNCE_CYCLES=1): gpio_in[3] 2-cycle glitch → DATA_IN stays 0, EDGE_CAP 0; stable high before edge k → DATA_IN=0x8 after k+4.
- Edge/irq: RISE_EN=0x8, IRQ_MASK=0x8, raise gpio_in[3] → EDGE_CAP=0x8, irq=1 one cycle later; write 0x8 to addr 5 → irq=0 following cycle; falling edge with FALL_EN=0 → no capture.
- Race: W1C on EDGE_CAP bit in same cycle as new capture → bit remains 1, irq stays 1.
- WIDTH=8: write 0xFFFF_FFFF to DATA_OUT → read 0x0000_00FF; DEBOUNCE_CYCLES=4 → deb latency 14 cycles max.

Source files
------------

// File: rtl/avalon_gpio_ctrl.sv
// avalon_gpio_ctrl: Avalon-MM GPIO peripheral.
// WIDTH outputs with atomic set/clear. WIDTH synchronised, tick-debounced inputs.
// Per-bit rise/fall edge capture and a maskable level interrupt.

// Per-bit input path: 2-flop synchroniser, then a 3-sample debounce on ticks.
module avalon_gpio_lane (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   input  logic tick,
   output logic deb,
   output logic rise,
   output logic fall
);
   logic meta, sync, s1, s2, agree;

   // Three consecutive tick samples (sync, s1, s2) must agree before deb follows.
   assign agree = (sync == s1) && (s1 == s2);
   // Edge pulses coincide with the edge at which deb changes.
   assign rise  = tick & agree & sync & ~deb;
   assign fall  = tick & agree & ~sync & deb;

   // Synchroniser every cycle; the debounce shift and update happen on tick only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         s1   <= 1'b0;
         s2   <= 1'b0;
         deb  <= 1'b0;
      end else begin
         meta <= pin;
         sync <= meta;
         if (tick) begin
            s1 <= sync;
            s2 <= s1;
            if (agree) deb <= sync;
         end
      end
   end
endmodule

module avalon_gpio_ctrl #(
   parameter int               WIDTH           = 32,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic             irq
);
   typedef enum logic [2:0] {
      A_DATA_IN  = 3'd0,
      A_DATA_OUT = 3'd1,
      A_OUT_SET  = 3'd2,
      A_OUT_CLR  = 3'd3,
      A_IRQ_MASK = 3'd4,
      A_EDGE_CAP = 3'd5,
      A_RISE_EN  = 3'd6,
      A_FALL_EN  = 3'd7
   } reg_addr_e;

   localparam int             CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0]    tick_cnt;
   logic             tick;
   logic [WIDTH-1:0] data_out, irq_mask, edge_cap, rise_en, fall_en;
   logic [WIDTH-1:0] deb, rise, fall, cap, w1c, wdata;
   logic [31:0]      rd_mux;

   // Zero-extend a WIDTH-bit register to the 32-bit bus.
   function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   assign tick     = (tick_cnt == TC);
   assign wdata    = avs_writedata[WIDTH-1:0];
   assign gpio_out = data_out;
   assign cap      = (rise & rise_en) | (fall & fall_en);
   assign w1c      = (avs_write && avs_address == A_EDGE_CAP) ? wdata : '0;

   // Free-running tick counter, wraps at terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_lane
         avalon_gpio_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .pin  (gpio_in[g]),
            .tick (tick),
            .deb  (deb[g]),
            .rise (rise[g]),
            .fall (fall[g])
         );
      end
   endgenerate

   // Control register writes; a capture in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= OUT_RESET;
         irq_mask <= '0;
         edge_cap <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
      end else begin
         edge_cap <= (edge_cap & ~w1c) | cap;
         if (avs_write) begin
            case (avs_address)
               A_DATA_OUT: data_out <= wdata;
               A_OUT_SET:  data_out <= data_out | wdata;
               A_OUT_CLR:  data_out <= data_out & ~wdata;
               A_IRQ_MASK: irq_mask <= wdata;
               A_RISE_EN:  rise_en  <= wdata;
               A_FALL_EN:  fall_en  <= wdata;
               default:    ;
            endcase
         end
      end
   end

   // Read mux; write-only registers read as zero.
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         A_DATA_IN:  rd_mux = ext(deb);
         A_DATA_OUT: rd_mux = ext(data_out);
         A_IRQ_MASK: rd_mux = ext(irq_mask);
         A_EDGE_CAP: rd_mux = ext(edge_cap);
         A_RISE_EN:  rd_mux = ext(rise_en);
         A_FALL_EN:  rd_mux = ext(fall_en);
         default:    rd_mux = '0;
      endcase
   end

   // Registered read data and interrupt; read data holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avs_readdata <= '0;
         irq          <= 1'b0;
      end else begin
         if (avs_read) avs_readdata <= rd_mux;
         irq <= |(edge_cap & irq_mask);
      end
   end
endmodule

// File: tb/tb_avalon_gpio_ctrl.sv
// Directed bench: DUT a (WIDTH=32, DEBOUNCE_CYCLES=1, OUT_RESET=5),
// DUT b (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_avalon_gpio_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [2:0]  a_addr = '0, b_addr = '0;
   logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
   logic [31:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata;
   logic [31:0] a_in = '0, a_out;
   logic [7:0]  b_in = '0, b_out;
   logic        a_irq, b_irq;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rd;
   int cnt;

   always #5 clk = ~clk;

   avalon_gpio_ctrl #(.WIDTH(32), .DEBOUNCE_CYCLES(1), .OUT_RESET(32'h5)) u_a (
      .clk(clk), .rst(rst), .avs_address(a_addr), .avs_read(a_read),
      .avs_write(a_write), .avs_writedata(a_wdata), .avs_readdata(a_rdata),
      .gpio_in(a_in), .gpio_out(a_out), .irq(a_irq)
   );

   avalon_gpio_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) u_b (
      .clk(clk), .rst(rst), .avs_address(b_addr), .avs_read(b_read),
      .avs_write(b_write), .avs_writedata(b_wdata), .avs_readdata(b_rdata),
      .gpio_in(b_in), .gpio_out(b_out), .irq(b_irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input bit b, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      if (b) begin b_addr = a; b_wdata = d; b_write = 1'b1; end
      else   begin a_addr = a; a_wdata = d; a_write = 1'b1; end
      @(negedge clk);
      a_write = 1'b0;
      b_write = 1'b0;
   endtask

   task automatic bus_rd(input bit b, input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      if (b) begin b_addr = a; b_read = 1'b1; end
      else   begin a_addr = a; a_read = 1'b1; end
      @(negedge clk);
      a_read = 1'b0;
      b_read = 1'b0;
      d = b ? b_rdata : a_rdata;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      // reset
      #2 rst = 1'b1;
      idle(2);
      chk("rst_gpio_out", a_out, 32'h5);
      chk("rst_irq", {31'b0, a_irq}, 32'h0);
      chk("rst_rdata", a_rdata, 32'h0);
      rst = 1'b0;
      bus_rd(0, 3'd0, rd); chk("rst_data_in", rd, 32'h0);
      bus_rd(0, 3'd5, rd); chk("rst_edge_cap", rd, 32'h0);

      // back-to-back DATA_OUT, OUT_SET, OUT_CLR
      @(negedge clk);
      a_addr = 3'd1; a_wdata = 32'hF0; a_write = 1'b1;
      @(negedge clk);
      chk("out_write", a_out, 32'hF0);
      a_addr = 3'd2; a_wdata = 32'h01;
      @(negedge clk);
      chk("out_set", a_out, 32'hF1);
      a_addr = 3'd3; a_wdata = 32'h10;
      @(negedge clk);
      chk("out_clr", a_out, 32'hE1);
      a_write = 1'b0;
      bus_rd(0, 3'd1, rd); chk("rd_data_out", rd, 32'hE1);
      bus_rd(0, 3'd2, rd); chk("rd_wo_zero", rd, 32'h0);

      // 2-cycle glitch must not reach deb
      bus_wr(0, 3'd6, 32'h8);
      bus_wr(0, 3'd4, 32'h8);
      @(negedge clk); a_in[3] = 1'b1;
      idle(2);        a_in[3] = 1'b0;
      idle(8);
      bus_rd(0, 3'd0, rd); chk("glitch_data_in", rd, 32'h0);
      bus_rd(0, 3'd5, rd); chk("glitch_edge_cap", rd, 32'h0);

      // stable high: deb/capture at k+4, irq at k+5
      @(negedge clk); a_in[3] = 1'b1;
      idle(4); chk("irq_k3", {31'b0, a_irq}, 32'h0);
      idle(1); chk("irq_k4", {31'b0, a_irq}, 32'h0);
      idle(1); chk("irq_k5", {31'b0, a_irq}, 32'h1);
      bus_rd(0, 3'd0, rd); chk("rise_data_in", rd, 32'h8);
      bus_rd(0, 3'd5, rd); chk("rise_edge_cap", rd, 32'h8);

      // W1C: irq drops the cycle after the write edge
      bus_wr(0, 3'd5, 32'h8);
      chk("w1c_irq_same", {31'b0, a_irq}, 32'h1);
      idle(1); chk("w1c_irq_next", {31'b0, a_irq}, 32'h0);

      // falling with FALL_EN=0: no capture
      @(negedge clk); a_in[3] = 1'b0;
      idle(8);
      bus_rd(0, 3'd0, rd); chk("fall_data_in", rd, 32'h0);
      bus_rd(0, 3'd5, rd); chk("fall_no_cap", rd, 32'h0);
      chk("fall_irq", {31'b0, a_irq}, 32'h0);

      // race: W1C at the same edge as a new fall capture
      bus_wr(0, 3'd7, 32'h8);
      @(negedge clk); a_in[3] = 1'b1;
      idle(8);
      chk("race_pre_irq", {31'b0, a_irq}, 32'h1);
      @(negedge clk); a_in[3] = 1'b0;    // edge k follows
      idle(4);                           // now after k+3
      a_addr = 3'd5; a_wdata = 32'h8; a_write = 1'b1;
      @(negedge clk);                    // after k+4: capture and clear together
      a_write = 1'b0;
      idle(2);
      chk("race_irq", {31'b0, a_irq}, 32'h1);
      bus_rd(0, 3'd5, rd); chk("race_edge_cap", rd, 32'h8);

      // masking: irq drops one cycle after IRQ_MASK write
      bus_wr(0, 3'd4, 32'h0);
      chk("mask_irq_same", {31'b0, a_irq}, 32'h1);
      idle(1); chk("mask_irq_next", {31'b0, a_irq}, 32'h0);
      bus_wr(0, 3'd5, 32'hFFFF_FFFF);
      bus_rd(0, 3'd5, rd); chk("cap_cleared", rd, 32'h0);

      // reset mid-debounce
      @(negedge clk); a_in[3] = 1'b1;
      idle(2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_gpio_out", a_out, 32'h5);
      chk("mid_rst_irq", {31'b0, a_irq}, 32'h0);
      chk("mid_rst_rdata", a_rdata, 32'h0);
      @(negedge clk); rst = 1'b0;
      bus_rd(0, 3'd0, rd); chk("post_rst_data_in", rd, 32'h0);
      bus_wr(0, 3'd6, 32'h8);
      bus_wr(0, 3'd4, 32'h8);
      idle(6);
      bus_rd(0, 3'd5, rd); chk("post_rst_cap", rd, 32'h8);
      bus_rd(0, 3'd0, rd); chk("post_rst_data_in2", rd, 32'h8);
      chk("post_rst_irq", {31'b0, a_irq}, 32'h1);

      // WIDTH=8 truncation
      bus_wr(1, 3'd1, 32'hFFFF_FFFF);
      chk("b_gpio_out", {24'b0, b_out}, 32'hFF);
      bus_rd(1, 3'd1, rd); chk("b_rd_data_out", rd, 32'hFF);
      bus_rd(1, 3'd2, rd); chk("b_rd_wo", rd, 32'h0);

      // DEBOUNCE_CYCLES=4: 4-cycle pulse is filtered, steady input within 14 cycles
      bus_wr(1, 3'd6, 32'h3);
      bus_wr(1, 3'd4, 32'h1);
      @(negedge clk); b_in[1] = 1'b1;
      idle(4);        b_in[1] = 1'b0;
      idle(20);
      bus_rd(1, 3'd5, rd); chk("b_glitch_cap", rd, 32'h0);
      @(negedge clk); b_in[0] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cnt++;
         if (b_irq) break;
      end
      chk("b_irq_latency", {31'b0, (cnt >= 11 && cnt <= 15)}, 32'h1);
      bus_rd(1, 3'd0, rd); chk("b_data_in", rd, 32'h1);
      bus_rd(1, 3'd5, rd); chk("b_edge_cap", rd, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
